// File: rtl/neck_detect_ctrl.sv
// neck_detect_ctrl: neck detector that arms on an ADC saturation run, trips the IGBT off, then holds and re-arms.
// Optional macro NECK_TRIP_CNT_EN adds a saturating trip_cnt output.
module neck_detect_ctrl #(
  parameter int DATA_W    = 13,
  parameter int SAT_VAL   = 4095,
  parameter int SAT_RUN   = 2,
  parameter int RUN_LEN   = 3,
  parameter int FO_THRESH = 5,
  parameter int SO_MIN    = 30,
  parameter int TO_LO     = -60,
  parameter int TO_HI     = 40,
  parameter int OFF_CYC   = 100000,
  parameter int HOLD_CYC  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_switch,
  input  logic              mode,
  input  logic              en_judge,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [DATA_W-1:0] first_order_data,
  input  logic [DATA_W-1:0] second_order_data,
  input  logic [DATA_W-1:0] third_order_data,
  output logic              power_switch,
  output logic [2:0]        state_o,
  output logic              trip_pulse
`ifdef NECK_TRIP_CNT_EN
  ,
  output logic [15:0]       trip_cnt
`endif
);
  localparam int SW = $clog2(SAT_RUN + 1);
  localparam int OW = $clog2(OFF_CYC + 1);
  localparam int HW = $clog2(HOLD_CYC + 2);
  localparam logic signed [DATA_W-1:0] SAT_S = DATA_W'(SAT_VAL);
  localparam logic signed [DATA_W-1:0] FO_S  = DATA_W'(FO_THRESH);
  localparam logic signed [DATA_W-1:0] SO_S  = DATA_W'(SO_MIN);
  localparam logic signed [DATA_W-1:0] TLO_S = DATA_W'(TO_LO);
  localparam logic signed [DATA_W-1:0] THI_S = DATA_W'(TO_HI);
  localparam logic [3:0] RL = 4'(RUN_LEN);

  typedef enum logic [2:0] {IDLE, WAIT_SAT, WAIT_REL, ARMED, OFF, HOLD} state_t;

  state_t                   state_q;
  logic                     mode_q;
  logic [3:0]               run_q, run_d;
  logic signed [DATA_W-1:0] prev_q;
  logic [SW-1:0]            sat_cnt_q;
  logic [OW-1:0]            off_cnt_q;
  logic [HW-1:0]            hold_cnt_q;
  logic signed [DATA_W-1:0] adc_s, fo_s, so_s, to_s;
  logic                     is_sat, fo_ok, win_ok, trip_evt;

  assign adc_s   = adc_data;
  assign fo_s    = first_order_data;
  assign so_s    = second_order_data;
  assign to_s    = third_order_data;
  assign state_o = state_q;

  always_comb begin
    is_sat   = adc_s == SAT_S;
    fo_ok    = fo_s > FO_S;
    win_ok   = fo_ok && so_s > SO_S && to_s > TLO_S && to_s < THI_S;
    run_d    = !fo_ok ? 4'd0 : (run_q == 4'd0 || fo_s > prev_q) ? (run_q == RL ? run_q : run_q + 4'd1) : 4'd1;
    // a strobe arriving on the same clk as a mode change is dropped with the cleared run
    trip_evt = ctrl_switch && state_q == ARMED && en_judge && mode == mode_q && (mode ? win_ok : run_d == RL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      power_switch <= 1'b0;
      trip_pulse   <= 1'b0;
      mode_q       <= 1'b0;
      run_q        <= '0;
      prev_q       <= '0;
      sat_cnt_q    <= '0;
      off_cnt_q    <= '0;
      hold_cnt_q   <= '0;
    end else begin
      trip_pulse <= 1'b0;
      mode_q     <= mode;
      if (!ctrl_switch) begin
        state_q      <= IDLE;
        power_switch <= 1'b0;
        run_q        <= '0;
        prev_q       <= '0;
        sat_cnt_q    <= '0;
        off_cnt_q    <= '0;
        hold_cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: state_q <= WAIT_SAT;
          WAIT_SAT: if (en_judge) begin
            if (is_sat && sat_cnt_q == SW'(SAT_RUN - 1)) begin
              state_q   <= WAIT_REL;
              sat_cnt_q <= '0;
            end else sat_cnt_q <= is_sat ? sat_cnt_q + 1'b1 : '0;
          end
          WAIT_REL: if (en_judge && !is_sat) begin
            state_q <= ARMED;
            run_q   <= '0;
            prev_q  <= '0;
          end
          ARMED: if (trip_evt) begin
            state_q      <= OFF;
            power_switch <= 1'b1;
            trip_pulse   <= 1'b1;
            off_cnt_q    <= '0;
          end else if (mode != mode_q) run_q <= '0;
          else if (en_judge) begin
            run_q  <= mode ? 4'd0 : run_d;
            prev_q <= fo_s;
          end
          OFF: if (off_cnt_q == OW'(OFF_CYC - 1)) begin
            power_switch <= 1'b0;
            off_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            state_q      <= (HOLD_CYC == 0) ? WAIT_SAT : HOLD;
          end else off_cnt_q <= off_cnt_q + 1'b1;
          HOLD: if (hold_cnt_q == HW'(HOLD_CYC - 1)) begin
            hold_cnt_q <= '0;
            state_q    <= WAIT_SAT;
          end else hold_cnt_q <= hold_cnt_q + 1'b1;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef NECK_TRIP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trip_cnt <= '0;
    else if (trip_evt && trip_cnt != 16'hFFFF) trip_cnt <= trip_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_neck_detect_ctrl.sv
// tb_neck_detect_ctrl: directed vector table plus hand sequences for OFF/HOLD timing and async reset.
module tb_neck_detect_ctrl;
  localparam int DW = 13;
  logic clk = 1'b0, rst = 1'b1, ctrl_switch = 1'b1, mode = 1'b0, en_judge = 1'b0;
  logic [DW-1:0] adc_data = '0, first_order_data = '0, second_order_data = '0, third_order_data = '0;
  logic power_switch, trip_pulse;
  logic [2:0] state_o;
  int errors = 0, checks = 0;
`ifdef NECK_TRIP_CNT_EN
  logic [15:0] trip_cnt;
  int exp_trips = 0;
`endif

  typedef struct {
    logic ctrl, md, en;
    int   adc, fo, so, tt;
    logic ps;
    int   st;
    logic tp;
  } vec_t;
  vec_t vecs[$];
  int ph[$];

  always #5 clk = ~clk;

  neck_detect_ctrl #(.DATA_W(DW), .OFF_CYC(20), .HOLD_CYC(10)) dut (
    .clk(clk), .rst(rst), .ctrl_switch(ctrl_switch), .mode(mode), .en_judge(en_judge),
    .adc_data(adc_data), .first_order_data(first_order_data),
    .second_order_data(second_order_data), .third_order_data(third_order_data),
    .power_switch(power_switch), .state_o(state_o), .trip_pulse(trip_pulse)
`ifdef NECK_TRIP_CNT_EN
    , .trip_cnt(trip_cnt)
`endif
  );

  function automatic void add(input logic c, m, e, input int a, f, s, t, input logic p, input int st, input logic tp);
    vecs.push_back('{c, m, e, a, f, s, t, p, st, tp});
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      ctrl_switch       = vecs[i].ctrl;
      mode              = vecs[i].md;
      en_judge          = vecs[i].en;
      adc_data          = DW'(vecs[i].adc);
      first_order_data  = DW'(vecs[i].fo);
      second_order_data = DW'(vecs[i].so);
      third_order_data  = DW'(vecs[i].tt);
      @(posedge clk);
      #1;
      chk("power_switch", i, int'(power_switch), int'(vecs[i].ps));
      chk("state", i, int'(state_o), vecs[i].st);
      chk("trip_pulse", i, int'(trip_pulse), int'(vecs[i].tp));
`ifdef NECK_TRIP_CNT_EN
      exp_trips += int'(vecs[i].tp);
      chk("trip_cnt", i, int'(trip_cnt), exp_trips);
`endif
    end
  endtask

  // Strobes with saturated ADC and rising fo are presented throughout OFF/HOLD and must be ignored.
  task automatic off_hold(input int id);
    int hi = 1, tps = 0, hs = 0, n = 0;
    en_judge = 1'b1;
    adc_data = DW'(4095);
    first_order_data = DW'(9);
    while (power_switch && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      hi += int'(power_switch);
      tps += int'(trip_pulse);
    end
    chk("off_cycles", id, hi, 20);
    chk("extra_trip_pulse", id, tps, 0);
    chk("state_after_off", id, int'(state_o), 5);
    while (state_o == 3'd5 && n < 400) begin
      hs++;
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold_cycles", id, hs, 10);
    chk("state_after_hold", id, int'(state_o), 1);
  endtask

  initial begin
    add(1,0,1,4095,0,0,0, 0,1,0); add(1,0,1,4095,0,0,0, 0,2,0); add(1,0,1,3000,0,0,0, 0,3,0);
    add(1,0,1,3000,6,0,0, 0,3,0); add(1,0,1,3000,7,0,0, 0,3,0); add(1,0,1,3000,8,0,0, 1,4,1);
    ph.push_back(vecs.size());
    add(1,0,1,1000,6,0,0, 0,1,0); add(1,0,1,1000,7,0,0, 0,1,0); add(1,0,1,1000,8,0,0, 0,1,0);
    add(1,0,1,4095,0,0,0, 0,1,0); add(1,0,1,100,0,0,0, 0,1,0);
    add(1,0,1,4095,0,0,0, 0,1,0); add(1,0,1,4095,0,0,0, 0,2,0);
    add(1,0,0,100,0,0,0, 0,2,0);  add(1,0,1,4095,0,0,0, 0,2,0); add(1,0,1,100,0,0,0, 0,3,0);
    add(1,0,1,100,6,0,0, 0,3,0);  add(1,0,1,100,7,0,0, 0,3,0);
    add(1,0,1,100,7,0,0, 0,3,0);  add(1,0,1,100,8,0,0, 0,3,0);
    add(1,0,1,100,4,0,0, 0,3,0);  add(1,0,1,100,6,0,0, 0,3,0);  add(1,0,1,100,7,0,0, 0,3,0);
    add(1,0,1,100,5,0,0, 0,3,0);  add(1,0,1,100,6,0,0, 0,3,0);  add(1,0,1,100,7,0,0, 0,3,0);
    add(1,0,0,100,9,0,0, 0,3,0);  add(1,0,1,100,9,0,0, 1,4,1);
    for (int k = 0; k < 4; k++) add(1,0,0,100,0,0,0, 1,4,0);
    add(0,0,0,100,0,0,0, 0,0,0);  add(0,0,0,100,0,0,0, 0,0,0);  add(1,0,0,100,0,0,0, 0,1,0);
    add(1,1,1,4095,0,0,0, 0,1,0); add(1,1,1,4095,0,0,0, 0,2,0); add(1,1,1,100,0,0,0, 0,3,0);
    add(1,1,1,100,6,31,40, 0,3,0); add(1,1,1,100,6,30,0, 0,3,0); add(1,1,1,100,5,31,0, 0,3,0);
    add(1,1,1,100,6,31,-60, 0,3,0); add(1,1,1,100,6,31,-59, 1,4,1);
    ph.push_back(vecs.size());
    add(1,0,1,4095,0,0,0, 0,1,0); add(1,0,1,4095,0,0,0, 0,2,0); add(1,0,1,100,0,0,0, 0,3,0);
    add(1,0,1,100,6,0,0, 0,3,0);  add(1,0,1,100,7,0,0, 0,3,0);
    add(1,1,0,100,7,0,0, 0,3,0);  add(1,0,0,100,7,0,0, 0,3,0);
    add(1,0,1,100,8,0,0, 0,3,0);  add(1,0,1,100,9,0,0, 0,3,0);  add(1,0,1,100,10,0,0, 1,4,1);
    ph.push_back(vecs.size());
    add(1,0,0,0,0,0,0, 0,1,0);
    add(1,0,1,4095,0,0,0, 0,1,0); add(1,0,1,4095,0,0,0, 0,2,0); add(1,0,1,100,0,0,0, 0,3,0);
    add(1,0,1,100,6,0,0, 0,3,0);  add(1,0,1,100,7,0,0, 0,3,0);  add(0,0,1,100,8,0,0, 0,0,0);
    ph.push_back(vecs.size());

    repeat (2) @(posedge clk);
    #1;
    chk("reset_power_switch", -1, int'(power_switch), 0);
    chk("reset_state", -1, int'(state_o), 0);
    chk("reset_trip_pulse", -1, int'(trip_pulse), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("state_after_rst", -1, int'(state_o), 1);

    run(0, ph[0]);
    off_hold(1);
    run(ph[0], ph[1]);
    off_hold(2);
    run(ph[1], ph[2]);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_power_switch", -2, int'(power_switch), 0);
    chk("async_rst_state", -2, int'(state_o), 0);
`ifdef NECK_TRIP_CNT_EN
    exp_trips = 0;
    chk("async_rst_trip_cnt", -2, int'(trip_cnt), exp_trips);
`endif
    @(negedge clk) rst = 1'b0;
    run(ph[2], ph[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
